// File: rtl/trace_pkg.sv
// Shared types for the retirement trace collector.
// Defines record kinds, the collector FSM states and the packed trace record.
package trace_pkg;

  localparam int unsigned TRACE_XLEN = 32;

  typedef enum logic [2:0] {
    REG   = 3'd0,
    JUMP  = 3'd1,
    BR_T  = 3'd2,
    BR_NT = 3'd3,
    STORE = 3'd4
  } trace_kind_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } trace_state_e;

  typedef struct packed {
    trace_kind_e             kind;
    logic [31:0]             cycle;
    logic [TRACE_XLEN-1:0]   tag;
    logic [31:0]             instr;
    logic [TRACE_XLEN-1:0]   dst;
    logic [TRACE_XLEN-1:0]   data;
    logic [TRACE_XLEN-1:0]   pc;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo_2w1r.sv
// DEPTH-entry record FIFO with two ordered write ports and one read port.
// Ports: push0/push0_rec (first), push1/push1_rec (second, only with push0),
//        pop, head (current head entry), count/free occupancy.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  logic [TRACE_REC_W-1:0]   push0_rec,
  input  logic                     push1,
  input  logic [TRACE_REC_W-1:0]   push1_rec,
  input  logic                     pop,
  output logic [TRACE_REC_W-1:0]   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [TRACE_REC_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW-1:0]          wr_idx0;
  logic [AW-1:0]          wr_idx1;
  logic                   do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wr_idx0 = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);
  assign count   = wr_ptr - rd_ptr;
  assign free    = DEPTH_C - count;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Record storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_idx0] <= push0_rec;
    if (push1) mem[wr_idx1] <= push1_rec;
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push0) + (AW+1)'(push1);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace collector: timestamps writeback/branch and store retirements
// into a dual-push FIFO drained over tr_valid/tr_ready, with finish-address
// detection and a no-retirement watchdog.
// Ports: wb_* writeback/branch event, st_* store event, tr_* trace output,
//        overflow/drop_cnt drop status, finish/timeout/state end-of-test status.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned     XLEN        = TRACE_XLEN,
  parameter int unsigned     DEPTH       = 16,
  parameter logic [XLEN-1:0] FINISH_ADDR = 32'h1000_0000,
  parameter int unsigned     WDOG_LIMIT  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic [2:0]             wb_kind,
  input  logic [XLEN-1:0]        wb_tag,
  input  logic [31:0]            wb_instr,
  input  logic [4:0]             wb_rd_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic                   st_valid,
  input  logic [XLEN-1:0]        st_tag,
  input  logic [31:0]            st_instr,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [XLEN-1:0]        st_data,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [TRACE_REC_W-1:0] tr_rec,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   finish,
  output logic                   timeout,
  output logic [1:0]             state
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_state_e   state_q, state_d;
  trace_rec_t     wb_rec, st_rec;
  logic [AW:0]    fifo_count, fifo_free;
  logic [31:0]    cycle_cnt;
  logic [31:0]    wdog_cnt;
  logic           capture_c, finish_d, timeout_d;
  logic           wb_acc, st_acc, wb_drop, st_drop;
  logic           any_evt, finish_hit, wdog_expire;
  logic [1:0]     drop_inc;
  logic [16:0]    drop_sum;

  // Record packing; fields that do not apply to a kind are forced to zero.
  always_comb begin
    wb_rec       = '0;
    wb_rec.kind  = trace_kind_e'(wb_kind);
    wb_rec.cycle = cycle_cnt;
    wb_rec.tag   = TRACE_XLEN'(wb_tag);
    wb_rec.instr = wb_instr;
    if (wb_kind == REG || wb_kind == JUMP) begin
      wb_rec.dst  = TRACE_XLEN'(wb_rd_addr);
      wb_rec.data = TRACE_XLEN'(wb_data);
    end
    if (wb_kind == JUMP || wb_kind == BR_T) wb_rec.pc = TRACE_XLEN'(wb_pc);

    st_rec       = '0;
    st_rec.kind  = STORE;
    st_rec.cycle = cycle_cnt;
    st_rec.tag   = TRACE_XLEN'(st_tag);
    st_rec.instr = st_instr;
    st_rec.dst   = TRACE_XLEN'(st_addr);
    st_rec.data  = TRACE_XLEN'(st_data);
  end

  // Admission uses pre-pop free slots; wb wins the last slot over the store.
  always_comb begin
    wb_acc  = 1'b0;
    st_acc  = 1'b0;
    wb_drop = 1'b0;
    st_drop = 1'b0;
    if (capture_c) begin
      wb_acc  = wb_valid && (fifo_free != '0);
      st_acc  = st_valid && (fifo_free > (AW+1)'(wb_acc));
      wb_drop = wb_valid && !wb_acc;
      st_drop = st_valid && !st_acc;
    end
  end

  trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0     (wb_acc || st_acc),
    .push0_rec (wb_acc ? wb_rec : st_rec),
    .push1     (wb_acc && st_acc),
    .push1_rec (st_rec),
    .pop       (tr_valid && tr_ready),
    .head      (tr_rec),
    .count     (fifo_count),
    .free      (fifo_free)
  );

  assign tr_valid = (fifo_count != '0);
  assign state    = state_q;

  assign any_evt     = wb_valid || st_valid;
  assign finish_hit  = capture_c && st_valid && (st_addr == FINISH_ADDR);
  assign wdog_expire = capture_c && !any_evt && (wdog_cnt == 32'(WDOG_LIMIT - 1));
  assign drop_inc    = 2'(wb_drop) + 2'(st_drop);
  assign drop_sum    = 17'(drop_cnt) + 17'(drop_inc);

  // Free-running timestamp, watchdog and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      wdog_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (capture_c) wdog_cnt <= any_evt ? '0 : wdog_cnt + 32'd1;
      drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow  <= overflow || wb_drop || st_drop;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state; finish beats a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (finish_hit) state_d = DRAIN;
               else if (wdog_expire) state_d = TIMEOUT;
      DRAIN:   if (fifo_count == '0) state_d = DONE;
      DONE:    state_d = DONE;
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    capture_c = (state_q == RUN);
    finish_d  = (state_d == DONE);
    timeout_d = (state_d == TIMEOUT);
  end

  // Status flags registered in step with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finish  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      finish  <= finish_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer.
module tb_retire_trace_buffer;
  import trace_pkg::*;

  localparam logic [31:0] FIN = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid, st_valid, tr_ready, tr_valid;
  logic [2:0]  wb_kind;
  logic [31:0] wb_tag, wb_instr, wb_data, wb_pc;
  logic [4:0]  wb_rd_addr;
  logic [31:0] st_tag, st_instr, st_addr, st_data;
  logic [TRACE_REC_W-1:0] tr_rec;
  logic        overflow, finish, timeout;
  logic [15:0] drop_cnt;
  logic [1:0]  state;
  trace_rec_t  rec;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc;
  int unsigned ts [18];
  int unsigned t;

  assign rec = trace_rec_t'(tr_rec);

  always #5 clk = ~clk;

  // Bench-side cycle model: matches the timestamp counter seen at each edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  retire_trace_buffer dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_kind(wb_kind), .wb_tag(wb_tag), .wb_instr(wb_instr),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .st_valid(st_valid), .st_tag(st_tag), .st_instr(st_instr),
    .st_addr(st_addr), .st_data(st_data),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_rec(tr_rec),
    .overflow(overflow), .drop_cnt(drop_cnt), .finish(finish),
    .timeout(timeout), .state(state)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_in();
    wb_valid = 1'b0; wb_kind = 3'd0; wb_tag = '0; wb_instr = '0;
    wb_rd_addr = '0; wb_data = '0; wb_pc = '0;
    st_valid = 1'b0; st_tag = '0; st_instr = '0; st_addr = '0; st_data = '0;
  endtask

  task automatic drive_wb(input logic [2:0] k, input logic [31:0] tg, input logic [4:0] rd,
                          input logic [31:0] d, input logic [31:0] p);
    wb_valid = 1'b1; wb_kind = k; wb_tag = tg; wb_instr = 32'h0000_0013 ^ tg;
    wb_rd_addr = rd; wb_data = d; wb_pc = p;
  endtask

  task automatic drive_st(input logic [31:0] tg, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_tag = tg; st_instr = 32'h0000_0023; st_addr = a; st_data = d;
  endtask

  task automatic do_reset();
    clear_in();
    tr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_in();
    tr_ready = 1'b0;

    // Reset values
    do_reset();
    chk("rst_tr_valid", tr_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_finish", finish, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_state", state, 0);

    // Single REG event at cycle 20
    repeat (20) @(negedge clk);
    tr_ready = 1'b1;
    drive_wb(REG, 32'h100, 5'd5, 32'h0000_00AA, 32'hDEAD_BEEF);
    @(negedge clk);
    clear_in();
    chk("t1_valid", tr_valid, 1);
    chk("t1_kind", rec.kind, REG);
    chk("t1_cycle", rec.cycle, 20);
    chk("t1_tag", rec.tag, 32'h100);
    chk("t1_dst", rec.dst, 5);
    chk("t1_data", rec.data, 32'hAA);
    chk("t1_pc", rec.pc, 0);
    @(negedge clk);
    chk("t1_empty", tr_valid, 0);

    // Same-cycle JUMP + store: ordered, equal timestamps
    t = cyc;
    drive_wb(JUMP, 32'h200, 5'd1, 32'h204, 32'h300);
    drive_st(32'h204, 32'h2000, 32'h1234);
    @(negedge clk);
    clear_in();
    chk("t2_kind0", rec.kind, JUMP);
    chk("t2_cycle0", rec.cycle, t);
    chk("t2_dst0", rec.dst, 1);
    chk("t2_pc0", rec.pc, 32'h300);
    @(negedge clk);
    chk("t2_kind1", rec.kind, STORE);
    chk("t2_cycle1", rec.cycle, t);
    chk("t2_dst1", rec.dst, 32'h2000);
    chk("t2_data1", rec.data, 32'h1234);
    chk("t2_pc1", rec.pc, 0);
    @(negedge clk);
    chk("t2_empty", tr_valid, 0);
    chk("t2_nodrop", drop_cnt, 0);

    // One free slot with both events: wb kept, store dropped
    tr_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive_wb(REG, 32'h400 + 32'(i), 5'd2, 32'(i), 32'h0);
      @(negedge clk);
    end
    drive_wb(REG, 32'h500, 5'd3, 32'h77, 32'h0);
    drive_st(32'h504, 32'h3000, 32'h55);
    @(negedge clk);
    clear_in();
    chk("t2b_drop", drop_cnt, 1);
    chk("t2b_ovf", overflow, 1);
    tr_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("t2b_last_kind", rec.kind, REG);
    chk("t2b_last_data", rec.data, 32'h77);
    @(negedge clk);
    chk("t2b_no_store", tr_valid, 0);
    // Mid-cycle reset clears drop status immediately
    #2 rst = 1'b1;
    #1;
    chk("t2b_rst_drop", drop_cnt, 0);
    chk("t2b_rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // 18 events into a 16-deep FIFO with the sink stalled
    do_reset();
    for (int i = 0; i < 18; i++) begin
      ts[i] = cyc;
      drive_wb(REG, 32'h1000 + 32'(4 * i), 5'(i), 32'(i), 32'h0);
      @(negedge clk);
    end
    clear_in();
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_valid", tr_valid, 1);
    chk("t3_hold_data", rec.data, 0);
    tr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", rec.data, 32'(i));
      chk("t3_cycle", rec.cycle, ts[i]);
      @(negedge clk);
    end
    chk("t3_empty", tr_valid, 0);

    // Finish store with 3 queued, then drain to DONE
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_wb(REG, 32'hA0 + 32'(4 * i), 5'd7, 32'(i), 32'h0);
      @(negedge clk);
    end
    clear_in();
    tr_ready = 1'b1;
    drive_st(32'hAC, FIN, 32'h1);
    @(negedge clk);
    clear_in();
    chk("t4_drain", state, DRAIN);
    chk("t4_head_b", rec.tag, 32'hA4);
    drive_wb(REG, 32'hF00, 5'd9, 32'h99, 32'h0);
    @(negedge clk);
    chk("t4_head_c", rec.tag, 32'hA8);
    @(negedge clk);
    chk("t4_head_fin_kind", rec.kind, STORE);
    chk("t4_head_fin_dst", rec.dst, FIN);
    @(negedge clk);
    chk("t4_empty", tr_valid, 0);
    chk("t4_not_done_yet", finish, 0);
    @(negedge clk);
    chk("t4_done", state, DONE);
    chk("t4_finish", finish, 1);
    chk("t4_drop", drop_cnt, 0);
    @(negedge clk);
    clear_in();
    chk("t4_ignored", tr_valid, 0);

    // Watchdog
    do_reset();
    repeat (999) @(negedge clk);
    chk("t5_pre_timeout", timeout, 0);
    chk("t5_pre_state", state, RUN);
    @(negedge clk);
    chk("t5_timeout", timeout, 1);
    chk("t5_state", state, TIMEOUT);
    drive_wb(REG, 32'h700, 5'd1, 32'h1, 32'h0);
    @(negedge clk);
    clear_in();
    chk("t5_no_rec", tr_valid, 0);
    chk("t5_no_drop", drop_cnt, 0);

    // Reset during DRAIN with 5 records queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_wb(REG, 32'hB0 + 32'(4 * i), 5'd4, 32'(i), 32'h0);
      @(negedge clk);
    end
    clear_in();
    drive_st(32'hC0, FIN, 32'h2);
    @(negedge clk);
    clear_in();
    chk("t6_drain", state, DRAIN);
    chk("t6_valid", tr_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", tr_valid, 0);
    chk("t6_rst_finish", finish, 0);
    chk("t6_rst_state", state, RUN);
    chk("t6_rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", tr_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesizable retirement-trace collector.
- Sits directly downstream of core_top's writeback/ALU-branch/LSU-store retirement outputs.
- Timestamps each architectural state change (register write, jump, branch outcome, store) into a dual-push FIFO and drains it over a valid/ready port to a log or debug sink.
- Also provides finish-address detection and a no-retirement watchdog, so simulation and FPGA runs share one end-of-test mechanism.

Parameters:
XLEN, 32, data/address width
DEPTH, 16, FIFO entries; power of 2, >= 4
FINISH_ADDR, 32'h1000_0000, store address that signals end of test
WDOG_LIMIT, 1000, idle cycles (no retirement) before timeout

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
wb_valid  in  1  writeback/branch retirement event
wb_kind  in  3  trace_kind_e: REG, JUMP, BR_T, BR_NT
wb_tag  in  XLEN  instruction tag (PC)
wb_instr  in  32  instruction word
wb_rd_addr  in  5  destination register (ignored for BR_T/BR_NT)
wb_data  in  XLEN  writeback data (ignored for BR_T/BR_NT)
wb_pc  in  XLEN  redirect PC (JUMP, BR_T only)
st_valid  in  1  store retirement event
st_tag  in  XLEN  store instruction tag
st_instr  in  32  store instruction word
st_addr  in  XLEN  store address
st_data  in  XLEN  masked store data
tr_valid  out  1  head record valid
tr_ready  in  1  sink accepts head record
tr_rec  out  TRACE_REC_W  head record (trace_rec_t)
overflow  out  1  sticky: at least one event dropped
drop_cnt  out  16  dropped-event count, saturating
finish  out  1  finish store seen and FIFO drained
timeout  out  1  watchdog expired
state  out  2  trace_state_e

Behaviour:
- Reset (async, rst=1): FIFO empty. Outputs tr_valid, overflow, finish, timeout = 0; drop_cnt = 0; state = RUN. Cycle and watchdog counters = 0. Reset mid-run discards all queued records.
- cycle_cnt: 32-bit, increments every cycle outside reset, wraps at 2^32. Record timestamp = cycle_cnt value in the capture cycle.
- Record fields:
  - kind, cycle, tag, instr.
  - dst: rd zero-extended for REG/JUMP, st_addr for STORE, 0 for BR_T/BR_NT.
  - data: wb_data for REG/JUMP, st_data for STORE, 0 otherwise.
  - pc: wb_pc for JUMP/BR_T, 0 otherwise.
- Capture (state RUN only):
  - Up to 2 pushes per cycle; wb event written before store event.
  - Free slots are evaluated before this cycle's pop; no same-cycle push-through when full.
  - Both events valid with 1 free slot: wb stored, store dropped.
  - Each dropped event sets overflow and increments drop_cnt; drop_cnt saturates at 0xFFFF.
- Output:
  - tr_valid = FIFO not empty; tr_rec = head entry, driven from registered storage.
  - Pop occurs when tr_valid & tr_ready.
  - Latency: event in cycle N is visible on tr_valid at N+1 when FIFO was empty.
  - tr_rec is held stable while tr_valid & ~tr_ready.
- Watchdog (RUN only):
  - Counter clears on any wb_valid or st_valid, otherwise increments.
  - Reaching WDOG_LIMIT -> TIMEOUT, timeout=1.
- State machine (trace_state_e):
  - RUN -> DRAIN on st_valid & st_addr==FINISH_ADDR. The finish store itself is recorded (or dropped per overflow rules). Finish takes priority over a simultaneous watchdog expiry.
  - DRAIN: inputs ignored and not counted as drops; FIFO continues to pop. When FIFO is empty -> DONE.
  - DONE: finish=1; terminal until rst.
  - TIMEOUT: inputs ignored; FIFO continues to drain; terminal until rst.

Decomposition:
- trace_pkg:
  - trace_kind_e {REG, JUMP, BR_T, BR_NT, STORE}
  - trace_rec_t (kind, cycle, tag, instr, dst, data, pc)
  - TRACE_REC_W
  - trace_state_e {RUN, DRAIN, DONE, TIMEOUT}
- Sub-module trace_fifo_2w1r: DEPTH-entry FIFO with 2 ordered write ports and 1 read port. Outputs count/free; pointers wrap modulo DEPTH with an extra wrap bit for full/empty.
- Top level: record packing, drop logic, counters, FSM.

Test Plan:
- Single REG event (x5=0x0000_00AA, tag 0x100) at cycle 20, tr_ready=1 -> tr_valid at cycle 21; rec kind=REG, cycle=20, dst=5, data=0xAA; FIFO empty at 22.
- Same-cycle wb JUMP + store (addr 0x2000, data 0x1234), FIFO empty -> two records in order JUMP then STORE, identical timestamps; no drop.
- tr_ready=0, 18 single events with DEPTH=16 -> first 16 queued, overflow=1, drop_cnt=2; after tr_ready=1, 16 records drain in order with original timestamps.
- Store to 0x1000_0000 with 3 records queued and tr_ready=1 -> state DRAIN; wb_valid in the following cycles is ignored with drop_cnt unchanged; after 4 pops, state DONE, finish=1.
- No events for 1000 cycles after reset -> timeout=1, state TIMEOUT; later wb_valid produces no record.
- Assert rst while FIFO holds 5 records and state=DRAIN -> same cycle: tr_valid=0, finish=0, state=RUN, drop_cnt=0.
